truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the number of Boolean inputs of the function under scan; legal range 1..6.
REQ-002 The module SHALL have parameter M = 2**N, derived, meaning the number of table rows; it SHALL not be overridden.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port start  input  1  requests a new sweep.
REQ-006 Port abort  input  1  terminates a running sweep.
REQ-007 Port sop_mask  input  M  is the minterm set: bit i = 1 means the SoP form is 1 at row i.
REQ-008 Port pos_mask  input  M  is the maxterm set: bit i = 1 means the PoS form is 0 at row i.
REQ-009 Port out_ready  input  1  is the downstream acceptance of the current row.
REQ-010 Port out_valid  output  1  means a row is presented.
REQ-011 Port out_idx  output  N  is the row number; its bits are the input vector, MSB = first variable.
REQ-012 Port out_sop, out_pos, out_mis  output  1 each: the SoP value, the PoS value, and their XOR for out_idx.
REQ-013 Port busy  output  1  is high in RUN; port done  output  1  is high in DONE.
REQ-014 Port mis_count  output  N+1  is the number of mismatching rows transferred this sweep.
REQ-015 Port first_mis  output  N  and first_mis_vld  output  1  report the lowest mismatching row transferred.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; every output SHALL be a function of registered state only.
REQ-017 In IDLE or DONE, start = 1 SHALL, on the same edge, latch sop_mask and pos_mask, set idx to 0, clear mis_count, first_mis and first_mis_vld, and enter RUN.
REQ-018 Mask inputs SHALL be ignored outside the start edge; changes during RUN SHALL not affect results.
REQ-019 In RUN: out_valid = 1; out_idx = idx; out_sop = sop_q[idx]; out_pos = ~pos_q[idx]; out_mis = out_sop ^ out_pos.
REQ-020 A transfer SHALL occur on an edge with out_valid = 1 and out_ready = 1; only then SHALL idx advance by 1.
REQ-021 With out_ready = 0, out_idx, out_sop, out_pos and out_mis SHALL hold stable.
REQ-022 On a transfer with out_mis = 1, mis_count SHALL increment by 1.
REQ-023 On that same transfer, if first_mis_vld = 0, first_mis SHALL load idx and first_mis_vld SHALL set.
REQ-024 mis_count SHALL be N+1 bits wide, so the value M cannot overflow and no saturation is needed.
REQ-025 A transfer at idx = M-1 SHALL enter DONE; idx SHALL not wrap, and no row SHALL be presented twice.
REQ-026 In DONE, done = 1 and out_valid = 0; the results SHALL hold until the next start or reset.
REQ-027 In RUN, start SHALL be ignored.
REQ-028 In RUN, abort = 1 SHALL enter IDLE on that edge with no transfer counted, even if out_ready = 1.
REQ-029 After an abort, mis_count and first_mis SHALL retain their partial values, and done SHALL not assert.
REQ-030 abort SHALL have priority over start and over a same-edge transfer; abort outside RUN SHALL have no effect.
REQ-031 With out_ready held at 1, sampling start on edge 0 SHALL present rows 0..M-1 on edges 1..M and raise done after edge M.

Reset
REQ-032 While rst_n = 0, the block SHALL immediately and independently of clk set: state IDLE; idx 0; latched masks 0; out_valid, busy, done 0; mis_count 0; first_mis 0; first_mis_vld 0.
REQ-033 The block SHALL leave reset on the first rising clk edge after rst_n rises.
REQ-034 Reset asserted mid-sweep SHALL discard all progress, and no transfer SHALL be counted on that edge.

Verification
REQ-035 N=2, sop=4'b0010, pos=4'b1101, out_ready=1 -> rows 0..3 show out_sop = out_pos = 0,1,0,0; mis_count=0; first_mis_vld=0; done after 4 transfers.
REQ-036 N=3, sop=8'b11011101, pos=8'b00100010 -> 8 transfers, mis_count=0, done=1.
REQ-037 N=2, sop=4'b0101, pos=4'b0000 -> mismatches at rows 1 and 3; mis_count=2; first_mis=1; first_mis_vld=1.
REQ-038 N=4 default, out_ready low for 3 cycles at idx=5 -> out_idx stays 5 and mis_count is unchanged; the sweep then completes 16 transfers.
REQ-039 Abort pulse at idx=6 together with start and out_ready=1 -> IDLE next edge; idx 6 not counted; done=0; partial mis_count retained.
REQ-040 rst_n pulled low between clk edges at idx=9 -> all outputs at reset values before the next edge; a subsequent start sweeps from row 0.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: sweeps all 2**N rows of a Boolean function.
// For each row it presents the SoP value, the PoS value and their XOR.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        begin a sweep / cancel a running sweep
//   sop_mask[M]         minterm set (row i is 1 in the SoP form)
//   pos_mask[M]         maxterm set (row i is 0 in the PoS form)
//   out_ready           downstream accepts the presented row
//   out_valid, out_idx  row presented and its number
//   out_sop/pos/mis     SoP value, PoS value, and their XOR
//   busy, done          sweep running / sweep finished
//   mis_count           mismatching rows transferred this sweep
//   first_mis(_vld)     lowest mismatching row transferred
module truth_table_scanner #(
    parameter int N = 4,
    localparam int M = 2**N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [M-1:0] sop_mask,
    input  logic [M-1:0] pos_mask,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_idx,
    output logic         out_sop,
    output logic         out_pos,
    output logic         out_mis,
    output logic         busy,
    output logic         done,
    output logic [N:0]   mis_count,
    output logic [N-1:0] first_mis,
    output logic         first_mis_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_nx;
    logic [N-1:0] r_idx;
    logic [N-1:0] w_idx_nx;
    logic [M-1:0] r_sop;
    logic [M-1:0] w_sop_nx;
    logic [M-1:0] r_pos;
    logic [M-1:0] w_pos_nx;
    logic [N:0]   r_cnt;
    logic [N:0]   w_cnt_nx;
    logic [N-1:0] r_first;
    logic [N-1:0] w_first_nx;
    logic         r_first_vld;
    logic         w_first_vld_nx;

    logic         w_run;
    logic         w_sop;
    logic         w_pos;
    logic         w_mis;
    logic         w_last;

    // Row outputs are derived from the latched masks and index only,
    // so a stalled row stays stable regardless of the mask inputs.
    assign w_run  = (r_state == S_RUN);
    assign w_sop  = w_run & r_sop[r_idx];
    assign w_pos  = w_run & ~r_pos[r_idx];
    assign w_mis  = w_sop ^ w_pos;
    assign w_last = (r_idx == N'(M - 1));

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_sop_nx       = r_sop;
        w_pos_nx       = r_pos;
        w_cnt_nx       = r_cnt;
        w_first_nx     = r_first;
        w_first_vld_nx = r_first_vld;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nx     = S_RUN;
                    w_idx_nx       = '0;
                    w_sop_nx       = sop_mask;
                    w_pos_nx       = pos_mask;
                    w_cnt_nx       = '0;
                    w_first_nx     = '0;
                    w_first_vld_nx = 1'b0;
                end
            end
            S_RUN: begin
                // Abort wins over a same-edge transfer; partial
                // results are kept for inspection.
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (out_ready) begin
                    if (w_mis) begin
                        w_cnt_nx = r_cnt + {{N{1'b0}}, 1'b1};
                        if (!r_first_vld) begin
                            w_first_nx     = r_idx;
                            w_first_vld_nx = 1'b1;
                        end
                    end
                    // Last row: stop without wrapping the index.
                    if (w_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_idx_nx = r_idx + {{(N-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_sop       <= '0;
            r_pos       <= '0;
            r_cnt       <= '0;
            r_first     <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_sop       <= w_sop_nx;
            r_pos       <= w_pos_nx;
            r_cnt       <= w_cnt_nx;
            r_first     <= w_first_nx;
            r_first_vld <= w_first_vld_nx;
        end
    end

    assign out_valid     = w_run;
    assign out_idx       = r_idx;
    assign out_sop       = w_sop;
    assign out_pos       = w_pos;
    assign out_mis       = w_mis;
    assign busy          = w_run;
    assign done          = (r_state == S_DONE);
    assign mis_count     = r_cnt;
    assign first_mis     = r_first;
    assign first_mis_vld = r_first_vld;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed testbench for truth_table_scanner at N = 2, 3 and 4.
// Three instances share clock, reset and control; masks are separate.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic rdy = 1'b0;

    logic [3:0]  sop2 = '0, pos2 = '0;
    logic [7:0]  sop3 = '0, pos3 = '0;
    logic [15:0] sop4 = '0, pos4 = '0;

    logic       v2, s2, p2, m2, b2, d2, fv2;
    logic [1:0] i2, f2;
    logic [2:0] c2;
    logic       v3, s3, p3, m3, b3, d3, fv3;
    logic [2:0] i3, f3;
    logic [3:0] c3;
    logic       v4, s4, p4, m4, b4, d4, fv4;
    logic [3:0] i4, f4;
    logic [4:0] c4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.N(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sop_mask(sop2), .pos_mask(pos2), .out_ready(rdy),
        .out_valid(v2), .out_idx(i2), .out_sop(s2), .out_pos(p2),
        .out_mis(m2), .busy(b2), .done(d2), .mis_count(c2),
        .first_mis(f2), .first_mis_vld(fv2)
    );

    truth_table_scanner #(.N(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sop_mask(sop3), .pos_mask(pos3), .out_ready(rdy),
        .out_valid(v3), .out_idx(i3), .out_sop(s3), .out_pos(p3),
        .out_mis(m3), .busy(b3), .done(d3), .mis_count(c3),
        .first_mis(f3), .first_mis_vld(fv3)
    );

    truth_table_scanner u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sop_mask(sop4), .pos_mask(pos4), .out_ready(rdy),
        .out_valid(v4), .out_idx(i4), .out_sop(s4), .out_pos(p4),
        .out_mis(m4), .busy(b4), .done(d4), .mis_count(c4),
        .first_mis(f4), .first_mis_vld(fv4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] e_sop2, e_pos2;

    initial begin
        // Reset state
        #2;
        chk("rst_valid", v4, 0);
        chk("rst_busy", b4, 0);
        chk("rst_done", d4, 0);
        chk("rst_idx", i4, 0);
        chk("rst_cnt", c4, 0);
        chk("rst_fvld", fv4, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_busy", b4, 0);

        // N=2 agreeing pair and N=3 agreeing pair
        sop2 = 4'b0010; pos2 = 4'b1101;
        sop3 = 8'b11011101; pos3 = 8'b00100010;
        sop4 = 16'hA5C3; pos4 = 16'h0F0F;
        rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        sop2 = '0; pos2 = '1; sop3 = '0; pos3 = '0;
        e_sop2 = 4'b0010;
        e_pos2 = 4'b0010;
        for (int r = 0; r < 4; r++) begin
            chk("n2_valid", v2, 1);
            chk("n2_idx", i2, r);
            chk("n2_sop", s2, e_sop2[r]);
            chk("n2_pos", p2, e_pos2[r]);
            tick();
        end
        chk("n2_done", d2, 1);
        chk("n2_valid_done", v2, 0);
        chk("n2_cnt", c2, 0);
        chk("n2_fvld", fv2, 0);
        chk("n3_busy", b3, 1);
        chk("n3_idx", i3, 4);
        repeat (4) tick();
        chk("n3_done", d3, 1);
        chk("n3_cnt", c3, 0);
        chk("n3_idx_hold", i3, 7);

        // N=2 mismatches at rows 1 and 3
        sop2 = 4'b0101; pos2 = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        sop2 = '0;
        repeat (4) tick();
        chk("n2m_done", d2, 1);
        chk("n2m_cnt", c2, 2);
        chk("n2m_first", f2, 1);
        chk("n2m_fvld", fv2, 1);
        repeat (12) tick();
        chk("n4_first_done", d4, 1);

        // N=4 stall at row 5; mismatch rows 0,1,4,5,8,10,12,14
        sop4 = 16'hA5C3; pos4 = 16'h0F0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        sop4 = 16'h0000; pos4 = 16'hFFFF;
        repeat (5) tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_idx", i4, 5);
            chk("stall_cnt", c4, 3);
            chk("stall_mis", m4, 1);
            tick();
        end
        rdy = 1'b1;
        chk("stall_idx_rel", i4, 5);
        repeat (10) tick();
        chk("n4_last_idx", i4, 15);
        chk("n4_not_done", d4, 0);
        tick();
        chk("n4_done", d4, 1);
        chk("n4_cnt", c4, 8);
        chk("n4_first", f4, 0);
        chk("n4_fvld", fv4, 1);
        tick();
        chk("n4_done_hold", d4, 1);
        chk("n4_cnt_hold", c4, 8);

        // Abort at row 6 together with start and ready
        sop4 = 16'hA5C3; pos4 = 16'h0F0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_abort_idx", i4, 6);
        abort = 1'b1; start = 1'b1;
        tick();
        chk("abort_busy", b4, 0);
        chk("abort_valid", v4, 0);
        chk("abort_done", d4, 0);
        chk("abort_cnt", c4, 4);
        chk("abort_fvld", fv4, 1);
        start = 1'b0;
        tick();
        chk("abort_idle", b4, 0);
        abort = 1'b0;

        // Async reset between edges at row 9
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_idx", i4, 9);
        chk("pre_rst_cnt", c4, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_idx", i4, 0);
        chk("arst_busy", b4, 0);
        chk("arst_valid", v4, 0);
        chk("arst_cnt", c4, 0);
        chk("arst_fvld", fv4, 0);
        chk("arst_first", f4, 0);
        tick();
        chk("arst_hold_idx", i4, 0);
        #2 rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", b4, 1);
        chk("restart_idx", i4, 0);
        chk("restart_cnt", c4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
